// File: rtl/uart_tx_axils.sv
// uart_tx_axils -- AXI4-Lite slave UART transmitter (8N1, LSB first).
//
// Software programs a clocks-per-bit divisor, pushes bytes into a small TX
// FIFO and either polls status or waits for the "done" interrupt. The
// serializer drains the FIFO back-to-back onto UART_TX.
//
// Register map (ADDR[3:2]):
//   0x0 DIV      RW  [15:0] clocks per bit (0 behaves as 1)
//   0x4 CTRL/STS     [0] tx_busy, [1] fifo_full, [2] fifo_empty,
//                    [3] overflow (W1C), [8] intr_enable (RW)
//   0x8 TXDATA   WO  write pushes WDATA[7:0]; reads 0
//   0xC          --  reads 0, writes ignored
//
// Ports:
//   S_AXI_ACLK         single clock, rising edge
//   S_AXI_ARESET       synchronous active-high reset
//   S_AXI_AW*/W*/B*    AXI4-Lite write channels (WSTRB ignored)
//   S_AXI_AR*/R*       AXI4-Lite read channels
//   UART_TX            serial output, idles high
//   IRQ                level interrupt: enabled, FIFO empty and serializer idle
module uart_tx_axils #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CLK_FREQ           = 100_000_000,
    parameter int DEFAULT_BAUD       = 9600,
    parameter int DATA_WIDTH         = 8,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            UART_TX,
    output logic                            IRQ
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int DIV_RESET = CLK_FREQ / DEFAULT_BAUD;
    localparam logic [15:0]      DIV_INIT  = 16'(DIV_RESET);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    tx_state_t tx_state, tx_next;

    logic [1:0]  aw_sel;
    logic [15:0] div_reg;
    logic        intr_enable;
    logic        overflow;
    logic        irq_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  fifo_full, fifo_empty;
    logic                  push_req, push_ok, fifo_pop;

    logic [15:0]           baud_cnt;
    logic [15:0]           frame_div;
    logic                  baud_done;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  tx_out;
    logic                  tx_busy;
    logic                  w_hs;

    // Inputs the register file never looks at (full-word writes only).
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_WSTRB, S_AXI_WDATA[31:16],
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // ---------------- write channel ----------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state <= W_IDLE;
            aw_sel   <= 2'd0;
        end else begin
            wr_state <= wr_next;
            if (wr_state == W_IDLE && S_AXI_AWVALID)
                aw_sel <= S_AXI_AWADDR[3:2];
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (S_AXI_AWVALID) wr_next = W_DATA;
            W_DATA:  if (S_AXI_WVALID)  wr_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY)  wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    assign S_AXI_AWREADY = (wr_state == W_IDLE);
    assign S_AXI_WREADY  = (wr_state == W_DATA);
    assign S_AXI_BVALID  = (wr_state == W_RESP);
    assign S_AXI_BRESP   = 2'b00;
    assign w_hs          = (wr_state == W_DATA) && S_AXI_WVALID;

    // Register updates happen on the W handshake edge.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            div_reg     <= DIV_INIT;
            intr_enable <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_hs && aw_sel == 2'd0)
                div_reg <= S_AXI_WDATA[15:0];
            if (w_hs && aw_sel == 2'd1) begin
                intr_enable <= S_AXI_WDATA[8];
                if (S_AXI_WDATA[3])
                    overflow <= 1'b0;
            end
            if (push_req && !push_ok)
                overflow <= 1'b1;
        end
    end

    // ---------------- read channel ----------------
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            2'd0: rd_mux[15:0] = div_reg;
            2'd1: begin
                rd_mux[0] = tx_busy;
                rd_mux[1] = fifo_full;
                rd_mux[2] = fifo_empty;
                rd_mux[3] = overflow;
                rd_mux[8] = intr_enable;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state <= R_IDLE;
            rdata_q  <= '0;
        end else begin
            rd_state <= rd_next;
            if (rd_state == R_IDLE && S_AXI_ARVALID)
                rdata_q <= rd_mux;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (S_AXI_ARVALID) rd_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY)  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    assign S_AXI_ARREADY = (rd_state == R_IDLE);
    assign S_AXI_RVALID  = (rd_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;

    // ---------------- TX FIFO ----------------
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push_req   = w_hs && (aw_sel == 2'd2);
    // A push into a full FIFO still fits if the serializer pops the same cycle.
    assign push_ok    = push_req && (!fifo_full || fifo_pop);

    always_ff @(posedge S_AXI_ACLK) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= S_AXI_WDATA[DATA_WIDTH-1:0];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---------------- serializer ----------------
    assign baud_done = (baud_cnt == frame_div - 16'd1);
    assign tx_busy   = (tx_state != TX_IDLE);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            tx_state <= TX_IDLE;
        else
            tx_state <= tx_next;
    end

    always_comb begin
        tx_next  = tx_state;
        fifo_pop = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    tx_next  = TX_START;
                end
            end
            TX_START: if (baud_done) tx_next = TX_DATA;
            TX_DATA:  if (baud_done && bit_cnt == BIT_LAST) tx_next = TX_STOP;
            TX_STOP: begin
                // Chain straight into the next start bit when more data waits.
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        tx_next  = TX_START;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // Divisor is captured per frame so mid-frame DIV writes only affect the next one.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            tx_out    <= 1'b1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_div <= 16'd1;
        end else if (fifo_pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            tx_out    <= 1'b0;
            baud_cnt  <= '0;
            frame_div <= (div_reg == 16'd0) ? 16'd1 : div_reg;
        end else if (tx_state != TX_IDLE) begin
            if (baud_done) begin
                baud_cnt <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_out  <= shift_reg[0];
                        bit_cnt <= '0;
                    end
                    TX_DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            tx_out <= 1'b1;
                        end else begin
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
                            tx_out    <= shift_reg[1];
                        end
                    end
                    default: tx_out <= 1'b1;
                endcase
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

    assign UART_TX = tx_out;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET)
            irq_q <= 1'b0;
        else
            irq_q <= intr_enable && fifo_empty && !tx_busy;
    end

    assign IRQ = irq_q;

endmodule
